pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage processor pipeline.
- Drives the write enables and bubble-inject (flush) controls of the PC, F/D, D/X, X/M and M/W latches.
- Resolves load-use hazards and taken-branch flushes.
- Sequences the multicycle multiplier/divider: start pulse, stall while busy, release on ready or timeout.

Parameters:
- MD_TIMEOUT, 64: maximum MD_WAIT cycles before forced release (≥2).
- REG_W, 5: register-specifier width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- d_rs  in  REG_W  rs of instruction in D
- d_rt  in  REG_W  rt of instruction in D
- d_uses_rt  in  1  D instruction reads rt
- x_rd  in  REG_W  destination register of instruction in X
- x_is_load  in  1  X instruction is lw
- x_is_md  in  1  X instruction is mul/div
- x_branch_taken  in  1  X resolved a taken branch/jump
- md_ready  in  1  multdiv result valid this cycle
- pc_we, fd_we, dx_we, xm_we, mw_we  out  1 each  latch write enables
- fd_flush, dx_flush, xm_flush  out  1 each  latch loads nop/zero instead of input
- md_start  out  1  one-cycle multdiv start
- md_busy  out  1  high in MD_WAIT
- md_timeout  out  1  sticky: a multdiv timed out
- state  out  1  0=RUN, 1=MD_WAIT (debug)

Behaviour:
- State and count registers:
  - Registers: state, cnt (width clog2(MD_TIMEOUT)+1), md_timeout.
  - reset low: state=RUN, cnt=0, md_timeout=0 immediately, regardless of clock, including mid-MD_WAIT.
  - While reset is low, every output is 0.
- All other outputs are combinational from the registered state and current inputs.
- Default (RUN, no event): all five we=1, all flushes=0, md_start=0, md_busy=0.
- Hazard definition: load_use = x_is_load & (x_rd!=0) & ((x_rd==d_rs) | (d_uses_rt & x_rd==d_rt)).
- RUN priority, highest first:
  1. x_is_md:
     - md_start=1; pc_we=fd_we=dx_we=0; xm_we=1, xm_flush=1; mw_we=1.
     - Next state MD_WAIT, cnt<=0.
  2. x_branch_taken: all we=1, fd_flush=dx_flush=1.
  3. load_use:
     - pc_we=fd_we=0; dx_we=1, dx_flush=1; xm_we=mw_we=1.
     - Lasts exactly 1 cycle, since the load leaves X.
  4. Otherwise: default.
- MD_WAIT:
  - md_busy=1, md_start=0; pc_we=fd_we=dx_we=0; xm_we=1, xm_flush=1; mw_we=1; cnt<=cnt+1.
  - md_ready=1:
    - Release that cycle: all we=1, all flushes=0, md_busy=0.
    - The result is captured by X/M. Next state RUN.
    - The instruction advancing into X next cycle is evaluated fresh; back-to-back md restarts normally.
  - Timeout: md_ready=0 and cnt==MD_TIMEOUT-1:
    - Forced release exactly as the ready case.
    - md_timeout<=1 (held until reset). Next state RUN.
  - md_ready and timeout in the same cycle: treated as normal ready; md_timeout not set.
  - x_branch_taken and load_use are ignored in MD_WAIT, because X holds the md instruction.
- Latency:
  - md instruction occupies X for N+1 cycles, where N = cycles until md_ready after md_start.
  - Load-use costs exactly 1 bubble; a taken branch costs 2 bubbles.
- mw_we is never deasserted.

Test Plan:
- Reset: hold reset=0 with x_is_md=1 -> all outputs 0. Release -> RUN, defaults, md_start=1 same cycle.
- Load-use: x_is_load=1, x_rd=5, d_rs=5 -> one cycle pc_we=fd_we=0, dx_flush=1; x_rd=0 case -> no stall; d_rt=5 with d_uses_rt=0 -> no stall.
- Branch: x_branch_taken=1 in RUN -> fd_flush=dx_flush=1, all we=1. Same with x_is_md=1 -> md path wins, no fd/dx flush.
- Multdiv: x_is_md=1, md_ready 4 cycles later -> md_start 1 cycle; md_busy 4 cycles, during which xm_flush=1 and pc_we=0; release cycle all we=1; back to RUN.
- Timeout: MD_TIMEOUT=8, md_ready never -> release on 8th MD_WAIT cycle, md_timeout=1 and sticky. md_ready on that same cycle -> md_timeout stays 0.
- Async reset mid-MD_WAIT (cycle 3) -> immediate RUN, cnt=0, md_busy=0 without a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and taken-branch hazards,
// plus multicycle mult/div start, busy-stall and ready/timeout release.
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int REG_W      = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_uses_rt,
    input  logic [REG_W-1:0] x_rd,
    input  logic             x_is_load,
    input  logic             x_is_md,
    input  logic             x_branch_taken,
    input  logic             md_ready,
    output logic             pc_we,
    output logic             fd_we,
    output logic             dx_we,
    output logic             xm_we,
    output logic             mw_we,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic             state
);

    localparam int CNT_W = $clog2(MD_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_timeout_q, md_timeout_d;

    logic load_use;
    logic pc_we_c, fd_we_c, dx_we_c, xm_we_c, mw_we_c;
    logic fd_flush_c, dx_flush_c, xm_flush_c;
    logic md_start_c, md_busy_c;

    assign load_use = x_is_load && (x_rd != '0) &&
                      ((x_rd == d_rs) || (d_uses_rt && (x_rd == d_rt)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        md_timeout_d = md_timeout_q;
        pc_we_c      = 1'b1;
        fd_we_c      = 1'b1;
        dx_we_c      = 1'b1;
        xm_we_c      = 1'b1;
        mw_we_c      = 1'b1;
        fd_flush_c   = 1'b0;
        dx_flush_c   = 1'b0;
        xm_flush_c   = 1'b0;
        md_start_c   = 1'b0;
        md_busy_c    = 1'b0;

        case (state_q)
            RUN: begin
                if (x_is_md) begin
                    // Hold the front end and bubble X/M while the unit is kicked off.
                    md_start_c = 1'b1;
                    pc_we_c    = 1'b0;
                    fd_we_c    = 1'b0;
                    dx_we_c    = 1'b0;
                    xm_flush_c = 1'b1;
                    state_d    = MD_WAIT;
                    cnt_d      = '0;
                end else if (x_branch_taken) begin
                    fd_flush_c = 1'b1;
                    dx_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_we_c    = 1'b0;
                    fd_we_c    = 1'b0;
                    dx_flush_c = 1'b1;
                end
            end
            MD_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (md_ready) begin
                    state_d = RUN;
                end else if (cnt_q == CNT_LAST) begin
                    // Forced release; the sticky flag records that the result is bogus.
                    state_d      = RUN;
                    md_timeout_d = 1'b1;
                end else begin
                    md_busy_c  = 1'b1;
                    pc_we_c    = 1'b0;
                    fd_we_c    = 1'b0;
                    dx_we_c    = 1'b0;
                    xm_flush_c = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // Every output is forced low while reset is held, independent of the clock.
    assign pc_we      = reset & pc_we_c;
    assign fd_we      = reset & fd_we_c;
    assign dx_we      = reset & dx_we_c;
    assign xm_we      = reset & xm_we_c;
    assign mw_we      = reset & mw_we_c;
    assign fd_flush   = reset & fd_flush_c;
    assign dx_flush   = reset & dx_flush_c;
    assign xm_flush   = reset & xm_flush_c;
    assign md_start   = reset & md_start_c;
    assign md_busy    = reset & md_busy_c;
    assign md_timeout = reset & md_timeout_q;
    assign state      = reset & (state_q == MD_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MD_TIMEOUT=8; outputs are compared as one
// packed vector {pc,fd,dx,xm,mw we, fd,dx,xm flush, md_start, md_busy, md_timeout, state}.
module tb_pipeline_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, x_rd;
    logic       d_uses_rt, x_is_load, x_is_md, x_branch_taken, md_ready;
    logic       pc_we, fd_we, dx_we, xm_we, mw_we;
    logic       fd_flush, dx_flush, xm_flush;
    logic       md_start, md_busy, md_timeout, state;
    logic [11:0] outs;

    int total = 0;
    int bad   = 0;

    localparam logic [11:0] ZERO    = 12'b00000_000_00_0_0;
    localparam logic [11:0] DEF     = 12'b11111_000_00_0_0;
    localparam logic [11:0] DEF_TO  = 12'b11111_000_00_1_0;
    localparam logic [11:0] BRANCH  = 12'b11111_110_00_0_0;
    localparam logic [11:0] LDUSE   = 12'b00111_010_00_0_0;
    localparam logic [11:0] MDSTART = 12'b00011_001_10_0_0;
    localparam logic [11:0] MDST_TO = 12'b00011_001_10_1_0;
    localparam logic [11:0] WAIT    = 12'b00011_001_01_0_1;
    localparam logic [11:0] WAIT_TO = 12'b00011_001_01_1_1;
    localparam logic [11:0] RELEASE = 12'b11111_000_00_0_1;

    always #5 clock = ~clock;

    assign outs = {pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, xm_flush,
                   md_start, md_busy, md_timeout, state};

    pipeline_hazard_ctrl #(.MD_TIMEOUT(8), .REG_W(5)) dut (
        .clock(clock), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_uses_rt(d_uses_rt),
        .x_rd(x_rd), .x_is_load(x_is_load), .x_is_md(x_is_md),
        .x_branch_taken(x_branch_taken), .md_ready(md_ready),
        .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout), .state(state)
    );

    task automatic idle_inputs();
        d_rs = 5'd0; d_rt = 5'd0; d_uses_rt = 1'b0; x_rd = 5'd0;
        x_is_load = 1'b0; x_is_md = 1'b0; x_branch_taken = 1'b0; md_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        x_is_md = 1'b1;
        #3;
        total++;
        if (outs !== ZERO) begin bad++; $display("FAIL reset_hold got=%b exp=%b", outs, ZERO); end
        next_cycle();
        total++;
        if (outs !== ZERO) begin bad++; $display("FAIL reset_hold_edge got=%b exp=%b", outs, ZERO); end
        reset = 1'b1;
        #1;
        total++;
        if (outs !== MDSTART) begin bad++; $display("FAIL reset_release_md got=%b exp=%b", outs, MDSTART); end
        x_is_md = 1'b0;
        #1;
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL reset_release_def got=%b exp=%b", outs, DEF); end
        next_cycle();
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL run_default got=%b exp=%b", outs, DEF); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        x_is_load = 1'b1; x_rd = 5'd5; d_rs = 5'd5;
        #1;
        total++;
        if (outs !== LDUSE) begin bad++; $display("FAIL lu_rs got=%b exp=%b", outs, LDUSE); end
        next_cycle();
        idle_inputs();
        #1;
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL lu_one_cycle got=%b exp=%b", outs, DEF); end
        x_is_load = 1'b1; x_rd = 5'd0; d_rs = 5'd0;
        #1;
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL lu_rd_zero got=%b exp=%b", outs, DEF); end
        x_rd = 5'd5; d_rs = 5'd3; d_rt = 5'd5; d_uses_rt = 1'b0;
        #1;
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL lu_rt_unused got=%b exp=%b", outs, DEF); end
        d_uses_rt = 1'b1;
        #1;
        total++;
        if (outs !== LDUSE) begin bad++; $display("FAIL lu_rt_used got=%b exp=%b", outs, LDUSE); end
        next_cycle();
        idle_inputs();
        #1;
    endtask

    task automatic test_branch();
        idle_inputs();
        x_branch_taken = 1'b1;
        #1;
        total++;
        if (outs !== BRANCH) begin bad++; $display("FAIL br_taken got=%b exp=%b", outs, BRANCH); end
        x_is_load = 1'b1; x_rd = 5'd7; d_rs = 5'd7;
        #1;
        total++;
        if (outs !== BRANCH) begin bad++; $display("FAIL br_over_lu got=%b exp=%b", outs, BRANCH); end
        x_is_md = 1'b1;
        #1;
        total++;
        if (outs !== MDSTART) begin bad++; $display("FAIL md_over_br got=%b exp=%b", outs, MDSTART); end
        idle_inputs();
        next_cycle();
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL br_stays_run got=%b exp=%b", outs, DEF); end
    endtask

    task automatic test_multdiv();
        idle_inputs();
        x_is_md = 1'b1;
        #1;
        total++;
        if (outs !== MDSTART) begin bad++; $display("FAIL md_start got=%b exp=%b", outs, MDSTART); end
        // Branch and load-use inputs must be ignored while waiting.
        x_branch_taken = 1'b1; x_is_load = 1'b1; x_rd = 5'd4; d_rs = 5'd4;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            total++;
            if (outs !== WAIT) begin bad++; $display("FAIL md_wait c=%0d got=%b exp=%b", c, outs, WAIT); end
        end
        next_cycle();
        md_ready = 1'b1;
        #1;
        total++;
        if (outs !== RELEASE) begin bad++; $display("FAIL md_release got=%b exp=%b", outs, RELEASE); end
        // Back-to-back multdiv: the next X instruction is also md.
        next_cycle();
        idle_inputs();
        x_is_md = 1'b1;
        #1;
        total++;
        if (outs !== MDSTART) begin bad++; $display("FAIL md_b2b_start got=%b exp=%b", outs, MDSTART); end
        next_cycle();
        md_ready = 1'b1;
        #1;
        total++;
        if (outs !== RELEASE) begin bad++; $display("FAIL md_b2b_release got=%b exp=%b", outs, RELEASE); end
        next_cycle();
        idle_inputs();
        #1;
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL md_back_run got=%b exp=%b", outs, DEF); end
    endtask

    task automatic test_timeout();
        // Ready arriving on the 8th wait cycle is a normal release.
        idle_inputs();
        x_is_md = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            total++;
            if (outs !== WAIT) begin bad++; $display("FAIL to_rdy_wait c=%0d got=%b exp=%b", c, outs, WAIT); end
        end
        next_cycle();
        md_ready = 1'b1;
        #1;
        total++;
        if (outs !== RELEASE) begin bad++; $display("FAIL to_rdy_release got=%b exp=%b", outs, RELEASE); end
        next_cycle();
        idle_inputs();
        #1;
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL to_rdy_noflag got=%b exp=%b", outs, DEF); end
        // Ready never arrives: forced release on the 8th wait cycle.
        x_is_md = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            total++;
            if (outs !== WAIT) begin bad++; $display("FAIL to_wait c=%0d got=%b exp=%b", c, outs, WAIT); end
        end
        next_cycle();
        total++;
        if (outs !== RELEASE) begin bad++; $display("FAIL to_release got=%b exp=%b", outs, RELEASE); end
        next_cycle();
        idle_inputs();
        #1;
        total++;
        if (outs !== DEF_TO) begin bad++; $display("FAIL to_flag got=%b exp=%b", outs, DEF_TO); end
        next_cycle();
        next_cycle();
        total++;
        if (outs !== DEF_TO) begin bad++; $display("FAIL to_sticky got=%b exp=%b", outs, DEF_TO); end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        x_is_md = 1'b1;
        #1;
        total++;
        if (outs !== MDST_TO) begin bad++; $display("FAIL ar_start got=%b exp=%b", outs, MDST_TO); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            total++;
            if (outs !== WAIT_TO) begin bad++; $display("FAIL ar_wait c=%0d got=%b exp=%b", c, outs, WAIT_TO); end
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (outs !== ZERO) begin bad++; $display("FAIL ar_outs_zero got=%b exp=%b", outs, ZERO); end
        idle_inputs();
        reset = 1'b1;
        #1;
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL ar_run_noedge got=%b exp=%b", outs, DEF); end
        next_cycle();
        total++;
        if (outs !== DEF) begin bad++; $display("FAIL ar_run_after got=%b exp=%b", outs, DEF); end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_multdiv();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
